// File: rtl/minmax_tracker_pkg.sv
// Shared types and defaults for the streaming min/max tracker.
package minmax_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;
  localparam logic [DEF_CNT_W-1:0] CNT_MAX = {DEF_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    SAT   = 2'd2
  } state_e;

  // Flat encodings for the state register, kept equal to the enum values.
  localparam logic [1:0] ST_EMPTY = 2'(EMPTY);
  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_SAT   = 2'(SAT);

endpackage

// File: rtl/minmax_tracker_if.sv
// Sample stream in, running statistics and per-sample flags out.
interface minmax_tracker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);

  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] min_val;
  logic [CNT_W-1:0] count;
  logic             gt_flag;
  logic             lt_flag;
  logic             eq_flag;
  logic             first_flag;
  logic             sat;
  logic             empty;

  modport master (
    output clear, in_valid, in_data,
    input  in_ready, out_valid, max_val, min_val, count,
           gt_flag, lt_flag, eq_flag, first_flag, sat, empty
  );

  modport slave (
    input  clear, in_valid, in_data,
    output in_ready, out_valid, max_val, min_val, count,
           gt_flag, lt_flag, eq_flag, first_flag, sat, empty
  );

endinterface

// File: rtl/minmax_tracker_cmp_unit.sv
// Unsigned WIDTH-bit magnitude comparator, purely combinational.
module cmp_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  assign lt = (i_a <  i_b);
  assign gt = (i_a >  i_b);
  assign eq = (i_a == i_b);

endmodule

// File: rtl/minmax_tracker.sv
// Two-stage streaming min/max tracker: capture, then compare against the
// registered extremes and update max/min/count/flags in one edge.
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic              clk,
  input logic              rst_n,
  minmax_tracker_if.slave  bus
);

  localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] L_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_s1_vld;
  logic [WIDTH-1:0] r_s1_data;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_min;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_vld;
  logic             r_gt;
  logic             r_lt;
  logic             r_eq;
  logic             r_first;
  logic             r_sat;

  logic             w_accept;
  logic             w_max_lt, w_max_gt, w_max_eq;
  logic             w_min_lt, w_min_gt, w_min_eq;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_unused;

  assign bus.in_ready = !bus.clear;
  assign w_accept     = bus.in_valid && !bus.clear;

  cmp_unit #(.WIDTH(WIDTH)) u_cmp_max (
    .i_a (r_s1_data),
    .i_b (r_max),
    .lt  (w_max_lt),
    .gt  (w_max_gt),
    .eq  (w_max_eq)
  );

  cmp_unit #(.WIDTH(WIDTH)) u_cmp_min (
    .i_a (r_s1_data),
    .i_b (r_min),
    .lt  (w_min_lt),
    .gt  (w_min_gt),
    .eq  (w_min_eq)
  );

  // Only gt/eq against max and lt against min feed the update.
  assign w_unused = ^{w_max_lt, w_min_gt, w_min_eq};

  assign w_cnt_next = (r_state == ST_SAT) ? r_cnt : (r_cnt + L_CNT_ONE);

  // Stage 1: capture. clear blocks acceptance, so the in-flight slot empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) r_s1_data <= bus.in_data;
    end
  end

  // Stage 2: compare against registered extremes and retire the sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_EMPTY;
      r_max     <= '0;
      r_min     <= '0;
      r_cnt     <= '0;
      r_out_vld <= 1'b0;
      r_gt      <= 1'b0;
      r_lt      <= 1'b0;
      r_eq      <= 1'b0;
      r_first   <= 1'b0;
      r_sat     <= 1'b0;
    end else if (bus.clear) begin
      r_state   <= ST_EMPTY;
      r_max     <= '0;
      r_min     <= '0;
      r_cnt     <= '0;
      r_out_vld <= 1'b0;
      r_gt      <= 1'b0;
      r_lt      <= 1'b0;
      r_eq      <= 1'b0;
      r_first   <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_out_vld <= r_s1_vld;
      if (r_s1_vld) begin
        case (r_state)
          ST_EMPTY: begin
            r_max   <= r_s1_data;
            r_min   <= r_s1_data;
            r_cnt   <= L_CNT_ONE;
            r_first <= 1'b1;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
            // A one-bit counter is already full after the first sample.
            if (L_CNT_ONE == L_CNT_MAX) begin
              r_state <= ST_SAT;
              r_sat   <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
          default: begin
            if (w_max_gt) r_max <= r_s1_data;
            if (w_min_lt) r_min <= r_s1_data;
            r_gt    <= w_max_gt;
            r_lt    <= w_min_lt;
            r_eq    <= w_max_eq;
            r_first <= 1'b0;
            r_cnt   <= w_cnt_next;
            if (w_cnt_next == L_CNT_MAX) begin
              r_state <= ST_SAT;
              r_sat   <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.out_valid  = r_out_vld;
  assign bus.max_val    = r_max;
  assign bus.min_val    = r_min;
  assign bus.count      = r_cnt;
  assign bus.gt_flag    = r_gt;
  assign bus.lt_flag    = r_lt;
  assign bus.eq_flag    = r_eq;
  assign bus.first_flag = r_first;
  assign bus.sat        = r_sat;
  assign bus.empty      = (r_state == ST_EMPTY);

endmodule
